// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, NRD registered read ports with
// write-first bypass, optional hardwired zero register and a sequenced clear.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NRD*$clog2(NREGS)-1:0]  rsel,
    output logic [NRD*XLEN-1:0]           rdata,
    input  logic                          wen0,
    input  logic [$clog2(NREGS)-1:0]      wsel0,
    input  logic [XLEN-1:0]               wdata0,
    input  logic                          wen1,
    input  logic [$clog2(NREGS)-1:0]      wsel1,
    input  logic [XLEN-1:0]               wdata1,
    input  logic                          clr_req,
    output logic                          clr_busy
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            clr_busy_q, clr_busy_d;
    logic [XLEN-1:0] regs_q  [NREGS];
    logic [XLEN-1:0] regs_d  [NREGS];
    logic [XLEN-1:0] rdata_q [NRD];
    logic [XLEN-1:0] rdata_d [NRD];
    logic [AW-1:0]   rsel_a  [NRD];
    logic            we0, we1;

    // Writes are dropped while clearing and, with a zero register, when aimed at r0.
    assign we0 = wen0 && !clr_busy_q && !((ZERO_REG != 0) && (wsel0 == '0));
    assign we1 = wen1 && !clr_busy_q && !((ZERO_REG != 0) && (wsel1 == '0));

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_port
            assign rsel_a[gi]                  = rsel[gi*AW +: AW];
            assign rdata[gi*XLEN +: XLEN]      = rdata_q[gi];
        end
    endgenerate

    assign clr_busy = clr_busy_q;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_busy_d = clr_busy_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_cnt_d  = '0;
                    clr_busy_d = 1'b1;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(NREGS - 1)) begin
                    state_d    = IDLE;
                    clr_busy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (clr_busy_q) begin
            regs_d[clr_cnt_q] = '0;
        end else begin
            if (we0) regs_d[wsel0] = wdata0;
            if (we1) regs_d[wsel1] = wdata1;
        end
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rdata_d[k] = regs_q[rsel_a[k]];
            if (clr_busy_q) begin
                if (rsel_a[k] == clr_cnt_q) rdata_d[k] = '0;
            end else if (we1 && (wsel1 == rsel_a[k])) begin
                rdata_d[k] = wdata1;
            end else if (we0 && (wsel0 == rsel_a[k])) begin
                rdata_d[k] = wdata0;
            end
            if ((ZERO_REG != 0) && (rsel_a[k] == '0)) rdata_d[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            for (int k = 0; k < NRD; k++) rdata_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
            regs_q     <= regs_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based model
// tracking register contents and the remaining length of any clear sequence.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NRD*AW-1:0]    rsel = '0;
    logic [NRD*XLEN-1:0]  rdata;
    logic                 wen0 = 1'b0, wen1 = 1'b0;
    logic [AW-1:0]        wsel0 = '0, wsel1 = '0;
    logic [XLEN-1:0]      wdata0 = '0, wdata1 = '0;
    logic                 clr_req = 1'b0;
    logic                 clr_busy;

    int passed = 0;
    int total  = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    int              m_clr_left = 0;
    int              m_clr_idx  = 0;
    logic [XLEN-1:0] exp_rd [NRD];
    logic            exp_busy;
    int              busy_cycles;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .rsel(rsel), .rdata(rdata),
        .wen0(wen0), .wsel0(wsel0), .wdata0(wdata0),
        .wen1(wen1), .wsel1(wsel1), .wdata1(wdata1),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] rd_port(input int k);
        return rdata[k*XLEN +: XLEN];
    endfunction

    // What a read of address a returns after the coming edge.
    function automatic logic [XLEN-1:0] model_read(input int a);
        if (a == 0) return '0;
        if (m_clr_left > 0) return (a == m_clr_idx) ? '0 : m_regs[a];
        if (wen1 && int'(wsel1) == a) return wdata1;
        if (wen0 && int'(wsel0) == a) return wdata0;
        return m_regs[a];
    endfunction

    task automatic step(input string tag);
        for (int k = 0; k < NRD; k++) exp_rd[k] = model_read(int'(rsel[k*AW +: AW]));
        if (m_clr_left > 0) begin
            m_regs[m_clr_idx] = '0;
            m_clr_idx++;
            m_clr_left--;
        end else begin
            if (wen0 && wsel0 != '0) m_regs[wsel0] = wdata0;
            if (wen1 && wsel1 != '0) m_regs[wsel1] = wdata1;
            if (clr_req) begin
                m_clr_left = NREGS;
                m_clr_idx  = 0;
            end
        end
        exp_busy = (m_clr_left > 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < NRD; k++)
            chk($sformatf("%s rd%0d", tag, k), rd_port(k), exp_rd[k]);
        chk({tag, " busy"}, {31'b0, clr_busy}, {31'b0, exp_busy});
    endtask

    task automatic quiet();
        wen0 = 1'b0; wen1 = 1'b0; clr_req = 1'b0;
    endtask

    task automatic set_rsel(input int k, input int a);
        rsel[k*AW +: AW] = AW'(a);
    endtask

    task automatic rand_rsel();
        for (int k = 0; k < NRD; k++) set_rsel(k, int'($urandom_range(0, NREGS - 1)));
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_clr_left = 0;
        m_clr_idx  = 0;
    endtask

    // Assert reset between edges, check outputs at once, release on the negedge.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < NRD; k++) chk($sformatf("%s rd%0d", tag, k), rd_port(k), '0);
        chk({tag, " busy"}, {31'b0, clr_busy}, 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill_all();
        for (int a = 1; a < NREGS; a += 2) begin
            wen0 = 1'b1; wsel0 = AW'(a); wdata0 = $urandom | 32'h1;
            wen1 = (a + 1 < NREGS); wsel1 = AW'((a + 1) % NREGS); wdata1 = $urandom | 32'h1;
            rand_rsel();
            step("fill");
        end
        quiet();
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NRD; k++) chk($sformatf("reset rd%0d", k), rd_port(k), '0);
        chk("reset busy", {31'b0, clr_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single write then dual read of the same register
        wen0 = 1'b1; wsel0 = 5'd5; wdata0 = 32'hDEADBEEF;
        step("w5");
        quiet(); set_rsel(0, 5); set_rsel(1, 5);
        step("r5");
        chk("r5 port0", rd_port(0), 32'hDEADBEEF);
        chk("r5 port1", rd_port(1), 32'hDEADBEEF);

        // Write-first bypass
        wen0 = 1'b1; wsel0 = 5'd15; wdata0 = 32'hAAAAAAAA;
        step("w15");
        set_rsel(1, 15); wdata0 = 32'h00000001;
        step("bypass15");
        chk("bypass15 port1", rd_port(1), 32'h00000001);
        quiet();
        step("r15");

        // Same-address collision, port 1 wins
        wen0 = 1'b1; wsel0 = 5'd10; wdata0 = 32'h11111111;
        wen1 = 1'b1; wsel1 = 5'd10; wdata1 = 32'h22222222;
        step("coll10");
        quiet(); set_rsel(0, 10);
        step("r10");
        chk("coll10 port0", rd_port(0), 32'h22222222);

        // Zero register: write discarded, no bypass
        wen0 = 1'b1; wsel0 = 5'd0; wdata0 = 32'hFFFFFFFF; set_rsel(0, 0);
        step("w0");
        chk("w0 bypass", rd_port(0), 32'h0);
        quiet();
        step("r0");
        chk("r0 read", rd_port(0), 32'h0);

        // Random traffic, bias toward address collisions
        for (int i = 0; i < 300; i++) begin
            rand_rsel();
            wen0 = 1'($urandom_range(0, 1));
            wen1 = 1'($urandom_range(0, 1));
            wsel0 = ($urandom_range(0, 3) == 0) ? rsel[AW-1:0] : AW'($urandom_range(0, NREGS - 1));
            wsel1 = ($urandom_range(0, 1) == 1) ? wsel0 : AW'($urandom_range(0, NREGS - 1));
            wdata0 = $urandom; wdata1 = $urandom;
            clr_req = ($urandom_range(0, 40) == 0);
            step("rand");
        end
        quiet();
        while (m_clr_left > 0) step("drain");

        // Full clear: busy length, dropped writes, everything zero afterwards
        fill_all();
        clr_req = 1'b1;
        step("clr start");
        busy_cycles = int'(clr_busy);
        clr_req = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            rand_rsel();
            wen0 = 1'b1; wsel0 = AW'($urandom_range(1, NREGS - 1)); wdata0 = $urandom | 32'h1;
            wen1 = 1'b1; wsel1 = AW'($urandom_range(1, NREGS - 1)); wdata1 = $urandom | 32'h1;
            step("clr run");
            busy_cycles += int'(clr_busy);
        end
        quiet();
        chk("clr busy cycles", 32'(busy_cycles), 32'(NREGS));
        for (int a = 0; a < NREGS; a += 2) begin
            set_rsel(0, a); set_rsel(1, a + 1);
            step("clr readback");
            chk($sformatf("clr zero r%0d", a), rd_port(0), 32'h0);
            chk($sformatf("clr zero r%0d", a + 1), rd_port(1), 32'h0);
        end

        // clr_req held high: back-to-back clears with one idle edge between
        fill_all();
        clr_req = 1'b1;
        for (int i = 0; i < 2 * NREGS + 4; i++) begin
            rand_rsel();
            step("clr held");
        end
        quiet();
        while (m_clr_left > 0) step("drain");

        // Reset mid-clear at clr_cnt = 7, then a fresh clear must start at 0
        fill_all();
        set_rsel(0, 20); set_rsel(1, 21);
        clr_req = 1'b1;
        step("abort start");
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) step("abort run");
        apply_reset("abort");
        wen0 = 1'b1; wsel0 = 5'd1; wdata0 = 32'h0000_1111;
        wen1 = 1'b1; wsel1 = 5'd2; wdata1 = 32'h0000_2222;
        set_rsel(0, 1); set_rsel(1, 2);
        step("post rst write");
        chk("post rst bypass", rd_port(0), 32'h0000_1111);
        quiet();
        clr_req = 1'b1;
        step("restart");
        clr_req = 1'b0;
        for (int i = 0; i < NREGS + 2; i++) step("restart run");
        quiet();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
